// File: rtl/hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold controller and the pipe
// registers that consume its hold codes.
package hold_ctrl_pkg;

  // Width of one per-stage hold code.
  localparam int HOLDPIP_W = 2;

  // Width of an instruction address (PC / redirect target).
  localparam int INST_ADDR_W = 32;

  // Hold codes seen by every pipe register:
  //   HOLD_NONE  - register advances normally
  //   HOLD_WAIT  - register keeps its current value
  //   HOLD_FLUSH - register loads its default (bubble) value
  localparam logic [HOLDPIP_W-1:0] HOLD_NONE  = 2'b00;
  localparam logic [HOLDPIP_W-1:0] HOLD_WAIT  = 2'b01;
  localparam logic [HOLDPIP_W-1:0] HOLD_FLUSH = 2'b10;

  // Reset / idle value for instruction addresses.
  localparam logic [INST_ADDR_W-1:0] INST_ADDR_ZERO = '0;

  // Controller state encodings.
  localparam logic [1:0] HOLD_S_RUN      = 2'd0;
  localparam logic [1:0] HOLD_S_FLUSH    = 2'd1;
  localparam logic [1:0] HOLD_S_MEM_WAIT = 2'd2;

endpackage : hold_ctrl_pkg

// File: rtl/hold_ctrl.sv
// Central pipeline hold controller.
//
// Merges the memory-bus wait, redirect (jump / mispredict) and load-use
// requests into one hold code per pipe register, plus the PC redirect
// strobe. Outputs are combinational so a stall acts in the same cycle;
// only the sequencing state is registered.
//
// Optional feature: define HOLD_TIMEOUT_EN to add a bus-wait watchdog
// that raises bus_err_o and flushes the pipe after TIMEOUT_CYCLES
// consecutive mem_busy_i cycles. Without it, bus_err_o is tied low and
// a bus wait is unbounded.
module hold_ctrl
  import hold_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 2
`ifdef HOLD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_busy_i,
  input  logic                   jump_req_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   load_use_req_i,
  output logic                   jump_en_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic [HOLDPIP_W-1:0]   hold_pc_o,
  output logic [HOLDPIP_W-1:0]   hold_if_id_o,
  output logic [HOLDPIP_W-1:0]   hold_id_ex_o,
  output logic [HOLDPIP_W-1:0]   hold_ex_mem_o,
  output logic [HOLDPIP_W-1:0]   hold_mem_wb_o,
  output logic                   bus_err_o
);

  // Flush counter must hold FLUSH_CYCLES-1; keep it at least one bit wide.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [1:0] REDIRECT_STATE =
    (FLUSH_CYCLES > 1) ? HOLD_S_FLUSH : HOLD_S_RUN;

`ifdef HOLD_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Registered sequencing state.
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_flush_cnt;
  logic                   r_pend_vld;
  logic [INST_ADDR_W-1:0] r_pend_addr;
`ifdef HOLD_TIMEOUT_EN
  logic [WAIT_W-1:0]      r_wait_cnt;
`endif

  // Next-state and output values from the priority encoder.
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_flush_cnt_nxt;
  logic                   w_pend_vld_nxt;
  logic [INST_ADDR_W-1:0] w_pend_addr_nxt;
  logic                   w_jump_en;
  logic [INST_ADDR_W-1:0] w_jump_addr;
  logic [HOLDPIP_W-1:0]   w_hold_pc;
  logic [HOLDPIP_W-1:0]   w_hold_if_id;
  logic [HOLDPIP_W-1:0]   w_hold_id_ex;
  logic [HOLDPIP_W-1:0]   w_hold_ex_mem;
  logic [HOLDPIP_W-1:0]   w_hold_mem_wb;
  logic                   w_bus_err;
`ifdef HOLD_TIMEOUT_EN
  logic [WAIT_W-1:0]      w_wait_cnt_nxt;
  logic                   w_timeout;
`endif

  // A jump latched during a bus wait is replayed on the first free cycle,
  // ahead of any new request (the new one comes from a wrong-path op).
  logic w_redirect_pend;
  assign w_redirect_pend = (r_state == HOLD_S_MEM_WAIT) && r_pend_vld;

`ifdef HOLD_TIMEOUT_EN
  // Watchdog fires on the TIMEOUT_CYCLES-th consecutive busy cycle.
  assign w_timeout = mem_busy_i && (r_wait_cnt == WAIT_LAST);
`endif

  // Priority encoder: reset > bus timeout > bus wait > redirect > load-use.
  always_comb begin
    // NOTE: every signal gets a default before the if-chain, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_jump_en       = 1'b0;
    w_jump_addr     = INST_ADDR_ZERO;
    w_hold_pc       = HOLD_NONE;
    w_hold_if_id    = HOLD_NONE;
    w_hold_id_ex    = HOLD_NONE;
    w_hold_ex_mem   = HOLD_NONE;
    w_hold_mem_wb   = HOLD_NONE;
    w_bus_err       = 1'b0;
`ifdef HOLD_TIMEOUT_EN
    w_wait_cnt_nxt  = (mem_busy_i && !w_timeout) ? r_wait_cnt + WAIT_W'(1)
                                                 : '0;
`endif

    if (rst) begin
      // Every pipe register loads its bubble while reset is held.
      w_hold_pc     = HOLD_FLUSH;
      w_hold_if_id  = HOLD_FLUSH;
      w_hold_id_ex  = HOLD_FLUSH;
      w_hold_ex_mem = HOLD_FLUSH;
      w_hold_mem_wb = HOLD_FLUSH;
    end
`ifdef HOLD_TIMEOUT_EN
    else if (w_timeout) begin
      // Abandon the stuck access: flush everything, drop any deferred jump.
      w_bus_err      = 1'b1;
      w_hold_pc      = HOLD_FLUSH;
      w_hold_if_id   = HOLD_FLUSH;
      w_hold_id_ex   = HOLD_FLUSH;
      w_hold_ex_mem  = HOLD_FLUSH;
      w_hold_mem_wb  = HOLD_FLUSH;
      w_pend_vld_nxt = 1'b0;
      w_state_nxt    = HOLD_S_RUN;
    end
`endif
    else if (mem_busy_i) begin
      // Freeze everything up to MEM; MEM/WB takes a bubble so the stalled
      // access is not written back twice.
      w_hold_pc     = HOLD_WAIT;
      w_hold_if_id  = HOLD_WAIT;
      w_hold_id_ex  = HOLD_WAIT;
      w_hold_ex_mem = HOLD_WAIT;
      w_hold_mem_wb = HOLD_FLUSH;
      w_state_nxt   = HOLD_S_MEM_WAIT;
      if (jump_req_i) begin
        // Defer the jump; a later request overwrites an earlier one.
        w_pend_vld_nxt  = 1'b1;
        w_pend_addr_nxt = jump_addr_i;
      end
    end
    else if (w_redirect_pend || jump_req_i) begin
      // Redirect: steer the PC and kill the two younger instructions.
      w_jump_en       = 1'b1;
      w_jump_addr     = w_redirect_pend ? r_pend_addr : jump_addr_i;
      w_hold_if_id    = HOLD_FLUSH;
      w_hold_id_ex    = HOLD_FLUSH;
      w_pend_vld_nxt  = 1'b0;
      w_flush_cnt_nxt = CNT_RELOAD;
      w_state_nxt     = REDIRECT_STATE;
    end
    else if (r_state == HOLD_S_FLUSH) begin
      // Keep flushing IF/ID while wrong-path fetches are still returning.
      // Load-use is ignored here: the dependent op is already being killed.
      w_hold_if_id    = HOLD_FLUSH;
      w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
      if (r_flush_cnt <= CNT_W'(1)) begin
        w_state_nxt = HOLD_S_RUN;
      end
    end
    else if (load_use_req_i) begin
      // One-cycle bubble between the load and its consumer. The first free
      // cycle after a bus wait behaves like S_RUN, so the hazard is honoured.
      w_hold_pc    = HOLD_WAIT;
      w_hold_if_id = HOLD_WAIT;
      w_hold_id_ex = HOLD_FLUSH;
      w_state_nxt  = HOLD_S_RUN;
    end
    else begin
      w_state_nxt = HOLD_S_RUN;
    end
  end

  // Sequencing state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      r_state     <= HOLD_S_RUN;
      r_flush_cnt <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= INST_ADDR_ZERO;
`ifdef HOLD_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
`ifdef HOLD_TIMEOUT_EN
      r_wait_cnt  <= w_wait_cnt_nxt;
`endif
    end
  end

  assign jump_en_o     = w_jump_en;
  assign jump_addr_o   = w_jump_addr;
  assign hold_pc_o     = w_hold_pc;
  assign hold_if_id_o  = w_hold_if_id;
  assign hold_id_ex_o  = w_hold_id_ex;
  assign hold_ex_mem_o = w_hold_ex_mem;
  assign hold_mem_wb_o = w_hold_mem_wb;
  assign bus_err_o     = w_bus_err;

endmodule : hold_ctrl

// File: tb/tb_hold_ctrl.sv
// Testbench for hold_ctrl: table-driven vectors through a scoreboard queue,
// plus hand-written reset and bus-timeout sequences. Honours HOLD_TIMEOUT_EN.
module tb_hold_ctrl;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] W = 2'b01;
  localparam logic [1:0] F = 2'b10;

  // Expected hold codes packed as {pc, if_id, id_ex, ex_mem, mem_wb}.
  localparam logic [9:0] H_NONE = {N, N, N, N, N};
  localparam logic [9:0] H_LU   = {W, W, F, N, N};
  localparam logic [9:0] H_JMP  = {N, F, F, N, N};
  localparam logic [9:0] H_FL1  = {N, F, N, N, N};
  localparam logic [9:0] H_BUSY = {W, W, W, W, F};
  localparam logic [9:0] H_ALLF = {F, F, F, F, F};

  typedef struct {
    logic        rst;
    logic        busy;
    logic        jreq;
    logic [31:0] jaddr;
    logic        lu;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [9:0]  exp_hold;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        load_use_req_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  hold_pc_o;
  logic [1:0]  hold_if_id_o;
  logic [1:0]  hold_id_ex_o;
  logic [1:0]  hold_ex_mem_o;
  logic [1:0]  hold_mem_wb_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  hold_ctrl #(
    .FLUSH_CYCLES   (2)
`ifdef HOLD_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_busy_i     (mem_busy_i),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .load_use_req_i (load_use_req_i),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .hold_ex_mem_o  (hold_ex_mem_o),
    .hold_mem_wb_o  (hold_mem_wb_o),
    .bus_err_o      (bus_err_o)
  );

  function automatic vec_t mk(input logic r, input logic b, input logic j,
                              input logic [31:0] ja, input logic l,
                              input logic ee, input logic [31:0] ea,
                              input logic [9:0] eh, input logic er);
    vec_t v;
    v.rst = r; v.busy = b; v.jreq = j; v.jaddr = ja; v.lu = l;
    v.exp_en = ee; v.exp_addr = ea; v.exp_hold = eh; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, tag, act, req);
    end
  endtask

  // Drive one cycle of stimulus just after the edge, queue its expectation,
  // then pop and compare mid-cycle while the combinational outputs are stable.
  task automatic step(input vec_t v, input int tag);
    vec_t e;
    @(posedge clk);
    #1;
    rst            = v.rst;
    mem_busy_i     = v.busy;
    jump_req_i     = v.jreq;
    jump_addr_i    = v.jaddr;
    load_use_req_i = v.lu;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("jump_en",   tag, {31'd0, jump_en_o}, {31'd0, e.exp_en});
    check("jump_addr", tag, jump_addr_o, e.exp_addr);
    check("holds",     tag,
          {22'd0, hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o},
          {22'd0, e.exp_hold});
    check("bus_err",   tag, {31'd0, bus_err_o}, {31'd0, e.exp_err});
  endtask

  initial begin
    rst = 1'b1; mem_busy_i = 1'b0; jump_req_i = 1'b0;
    jump_addr_i = '0; load_use_req_i = 1'b0;

    //          rst  busy jreq addr          lu   en   exp_addr      holds   err
    // Reset: everything flushed even with requests present.
    tbl.push_back(mk(1, 0, 1, 32'h0000_0040, 1, 0, 32'h0,        H_ALLF, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,        H_ALLF, 0));
    // Idle, then a single load-use bubble.
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        H_LU,   0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // Jump with a two-cycle flush.
    tbl.push_back(mk(0, 0, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // Jump arriving during a 3-cycle bus wait is deferred.
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0000_0200, 0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0200, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // Jump and load-use together: redirect wins; load-use ignored in flush.
    tbl.push_back(mk(0, 0, 1, 32'h0000_0300, 1, 1, 32'h0000_0300, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // New jump during flush restarts the sequence.
    tbl.push_back(mk(0, 0, 1, 32'h0000_0400, 0, 1, 32'h0000_0400, H_JMP, 0));
    tbl.push_back(mk(0, 0, 1, 32'h0000_0500, 0, 1, 32'h0000_0500, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // Latest deferred jump overwrites; pending beats a new request at exit.
    tbl.push_back(mk(0, 1, 1, 32'h0000_0600, 0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0000_0700, 0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 0, 1, 32'h0000_0800, 0, 1, 32'h0000_0700, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // New jump taken directly on the cycle a wait ends with nothing pending.
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 0, 1, 32'h0000_0900, 0, 1, 32'h0000_0900, H_JMP, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));
    // Busy beats load-use.
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,        H_BUSY, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    // Reset mid-sequence: enter flush, latch a deferred jump, then reset.
    step(mk(0, 0, 1, 32'h0000_0A00, 0, 1, 32'h0000_0A00, H_JMP, 0), 100);
    step(mk(0, 1, 1, 32'h0000_0B00, 0, 0, 32'h0,        H_BUSY, 0), 101);
    step(mk(1, 0, 1, 32'h0000_0C00, 0, 0, 32'h0,        H_ALLF, 0), 102);
    step(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,        H_ALLF, 0), 103);
    step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0), 104);
    step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0), 105);

    // Six busy cycles with a jump in the second one.
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 200);
    step(mk(0, 1, 1, 32'h0000_0D00, 0, 0, 32'h0,        H_BUSY, 0), 201);
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 202);
`ifdef HOLD_TIMEOUT_EN
    // 4th busy cycle times out; the counter restarts and the jump is dropped.
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_ALLF, 1), 203);
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 204);
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 205);
    step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0), 206);
`else
    // Unbounded wait: no error, deferred jump replays when the bus frees.
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 203);
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 204);
    step(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        H_BUSY, 0), 205);
    step(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0D00, H_JMP, 0), 206);
    step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_FL1,  0), 207);
`endif
    step(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        H_NONE, 0), 208);

    check("scoreboard_drain", 999, exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hold_ctrl
